// File: rtl/psum_accum_if.sv
// Handshake and BRAM port bundle for the psum accumulate/drain controller.
interface psum_accum_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_psum;
   logic                  in_first;
   logic                  drain_start;
   logic [ADDR_WIDTH-1:0] drain_base;
   logic [ADDR_WIDTH-1:0] drain_len;
   logic                  drain_busy;
   logic                  drain_done;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] bram_raddr;
   logic [DATA_WIDTH-1:0] bram_odat;
   logic [ADDR_WIDTH-1:0] bram_waddr;
   logic [DATA_WIDTH-1:0] bram_idat;
   logic                  bram_wren;

   modport slave (
      input  in_valid, in_addr, in_psum, in_first,
      input  drain_start, drain_base, drain_len,
      input  out_ready, bram_odat,
      output in_ready, drain_busy, drain_done,
      output out_valid, out_data,
      output bram_raddr, bram_waddr, bram_idat, bram_wren
   );

   modport master (
      output in_valid, in_addr, in_psum, in_first,
      output drain_start, drain_base, drain_len,
      output out_ready, bram_odat,
      input  in_ready, drain_busy, drain_done,
      input  out_valid, out_data,
      input  bram_raddr, bram_waddr, bram_idat, bram_wren
   );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Psum BRAM read-modify-write accumulator with streaming range drain.
// Optional PSUM_SAT_EN: saturating signed add instead of wrapping add.
module psum_accum_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   psum_accum_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t          state_q, state_d;
   logic            s1_valid;
   logic [AW-1:0]   s1_addr;
   logic [DW-1:0]   s1_psum;
   logic            s1_first;
   logic            wr_last_valid;
   logic [AW-1:0]   wr_last_addr;
   logic [DW-1:0]   wr_last_data;
   logic [AW-1:0]   raddr_q;
   logic [AW-1:0]   rd_addr;
   logic [AW-1:0]   rd_left;
   logic [AW-1:0]   out_left;
   logic            rd_inflight;
   logic [DW-1:0]   fifo_q [2];
   logic            wr_ptr, rd_ptr;
   logic [1:0]      cnt;

   logic            accept, fwd_hit, issue, pop, last, done, busy;
   logic [DW-1:0]   old, sum;
   logic [1:0]      occ;

   function automatic logic [DW-1:0] add_psum(
      input logic [DW-1:0] a,
      input logic [DW-1:0] b
   );
      logic [DW-1:0] s;
      s = a + b;
`ifdef PSUM_SAT_EN
      if (a[DW-1] == b[DW-1] && s[DW-1] != a[DW-1])
         s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                     : {1'b0, {(DW-1){1'b1}}};
`endif
      return s;
   endfunction

   assign bus.in_ready = ~rst & (state_q == IDLE) & ~bus.drain_start;
   assign accept  = bus.in_valid & bus.in_ready;

   // Same-address write on the edge that sampled our read: BRAM data is stale.
   assign fwd_hit = wr_last_valid & (wr_last_addr == s1_addr);
   assign old     = fwd_hit ? wr_last_data : bus.bram_odat;
   assign sum     = add_psum(s1_first ? '0 : old, s1_psum);

   assign bus.bram_wren  = s1_valid & ~rst;
   assign bus.bram_waddr = rst ? '0 : s1_addr;
   assign bus.bram_idat  = rst ? '0 : sum;

   assign occ   = cnt + {1'b0, rd_inflight};
   assign issue = (state_q == DRAIN) & (rd_left != '0) & (occ < 2'd2);
   assign bus.out_valid = (state_q == DRAIN) & (cnt != 2'd0);
   assign bus.out_data  = fifo_q[rd_ptr];
   assign pop  = bus.out_valid & bus.out_ready;
   assign last = pop & (out_left == AW'(1));

   assign bus.bram_raddr = rst    ? '0 :
                           accept ? bus.in_addr :
                           issue  ? rd_addr : raddr_q;

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         IDLE: if (bus.drain_start) state_d = DRAIN;
         DRAIN: begin
            busy = 1'b1;
            done = (out_left == '0) | last;
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.drain_busy = busy;
   assign bus.drain_done = done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         s1_valid      <= 1'b0;
         s1_addr       <= '0;
         s1_psum       <= '0;
         s1_first      <= 1'b0;
         wr_last_valid <= 1'b0;
         wr_last_addr  <= '0;
         wr_last_data  <= '0;
         raddr_q       <= '0;
         rd_addr       <= '0;
         rd_left       <= '0;
         out_left      <= '0;
         rd_inflight   <= 1'b0;
         fifo_q[0]     <= '0;
         fifo_q[1]     <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         cnt           <= 2'd0;
      end else begin
         state_q     <= state_d;
         s1_valid    <= accept;
         raddr_q     <= bus.bram_raddr;
         rd_inflight <= issue;
         if (accept) begin
            s1_addr  <= bus.in_addr;
            s1_psum  <= bus.in_psum;
            s1_first <= bus.in_first;
         end
         wr_last_valid <= s1_valid;
         if (s1_valid) begin
            wr_last_addr <= s1_addr;
            wr_last_data <= sum;
         end
         if (state_q == IDLE && bus.drain_start) begin
            rd_addr  <= bus.drain_base;
            rd_left  <= bus.drain_len;
            out_left <= bus.drain_len;
         end else begin
            if (issue) begin
               rd_addr <= rd_addr + AW'(1);
               rd_left <= rd_left - AW'(1);
            end
            if (pop) out_left <= out_left - AW'(1);
         end
         if (rd_inflight) begin
            fifo_q[wr_ptr] <= bus.bram_odat;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, rd_inflight} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl with a 1-cycle registered BRAM model.
module tb_psum_accum_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] mem [0:63] = '{default: 32'd0};
   logic [31:0] exp_q [0:3];

   psum_accum_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   psum_accum_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Read-before-write BRAM: a read on the write edge returns the old word.
   always @(posedge clk) begin
      if (bus.bram_wren) mem[bus.bram_waddr[5:0]] <= bus.bram_idat;
      bus.bram_odat <= mem[bus.bram_raddr[5:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] p,
                       input logic f);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_psum  = p;
      bus.in_first = f;
      #1;
      check("send_ready", 32'(bus.in_ready), 32'd1);
      step;
      bus.in_valid = 1'b0;
   endtask

   // Caller has raised drain_start with base/len this cycle.
   task automatic run_drain(input logic [31:0] len, input bit tgl);
      int k;
      logic stalled;
      logic [31:0] held;
      k = 0;
      stalled = 1'b0;
      held = 32'd0;
      #1;
      check("drain_in_ready", 32'(bus.in_ready), 32'd0);
      step;
      bus.drain_start = 1'b0;
      bus.in_valid = 1'b0;
      for (int cyc = 0; cyc < 60 && k < int'(len); cyc++) begin
         bus.out_ready = tgl ? cyc[0] : 1'b1;
         #1;
         if (stalled && bus.out_valid)
            check("stall_stable", bus.out_data, held);
         stalled = bus.out_valid & ~bus.out_ready;
         held = bus.out_data;
         if (bus.out_valid && bus.out_ready) begin
            check("drain_data", bus.out_data, exp_q[k]);
            check("drain_done", 32'(bus.drain_done),
                  32'(k == int'(len) - 1));
            k++;
         end else begin
            check("drain_no_done", 32'(bus.drain_done), 32'd0);
         end
         step;
      end
      bus.out_ready = 1'b0;
      check("drain_count", 32'(k), len);
      check("drain_idle", 32'(bus.drain_busy), 32'd0);
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_addr     = '0;
      bus.in_psum     = '0;
      bus.in_first    = 1'b0;
      bus.drain_start = 1'b0;
      bus.drain_base  = '0;
      bus.drain_len   = '0;
      bus.out_ready   = 1'b0;
      step;
      step;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wren", 32'(bus.bram_wren), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.drain_busy), 32'd0);
      check("rst_raddr", bus.bram_raddr, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(bus.in_ready), 32'd1);

      send(32'd5, 32'd10, 1'b1);
      check("t1_wren", 32'(bus.bram_wren), 32'd1);
      check("t1_waddr", bus.bram_waddr, 32'd5);
      check("t1_idat0", bus.bram_idat, 32'd10);
      step; step; step;
      send(32'd5, 32'd7, 1'b0);
      check("t1_idat1", bus.bram_idat, 32'd17);
      step;
      check("t1_mem5", mem[5], 32'd17);

      bus.in_valid = 1'b1;
      bus.in_addr  = 32'd9;
      bus.in_psum  = 32'd3;
      bus.in_first = 1'b1;
      step;
      check("t2_idat0", bus.bram_idat, 32'd3);
      bus.in_psum  = 32'd4;
      bus.in_first = 1'b0;
      step;
      check("t2_wren1", 32'(bus.bram_wren), 32'd1);
      check("t2_idat1", bus.bram_idat, 32'd7);
      bus.in_psum = 32'd5;
      step;
      check("t2_wren2", 32'(bus.bram_wren), 32'd1);
      check("t2_idat2", bus.bram_idat, 32'd12);
      bus.in_valid = 1'b0;
      step;
      check("t2_wren_off", 32'(bus.bram_wren), 32'd0);
      check("t2_mem9", mem[9], 32'd12);

      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_addr = 32'(i);
         bus.in_psum = 32'(i + 1);
         step;
      end
      bus.in_valid = 1'b0;
      step;
      exp_q[0] = 32'd1;
      exp_q[1] = 32'd2;
      exp_q[2] = 32'd3;
      exp_q[3] = 32'd4;
      bus.drain_start = 1'b1;
      bus.drain_base  = 32'd0;
      bus.drain_len   = 32'd4;
      run_drain(32'd4, 1'b0);

      bus.drain_start = 1'b1;
      run_drain(32'd4, 1'b1);

      bus.drain_start = 1'b1;
      step;
      bus.drain_start = 1'b0;
      step; step; step;
      check("mid_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      step;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_busy", 32'(bus.drain_busy), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      step;
      check("mid_idle_ready", 32'(bus.in_ready), 32'd1);
      check("mid_idle_valid", 32'(bus.out_valid), 32'd0);

      send(32'd2, 32'd100, 1'b0);
      bus.in_valid    = 1'b1;
      bus.in_addr     = 32'd2;
      bus.in_psum     = 32'd999;
      bus.in_first    = 1'b0;
      bus.drain_start = 1'b1;
      bus.drain_base  = 32'd2;
      bus.drain_len   = 32'd1;
      #1;
      check("t5_s1_wren", 32'(bus.bram_wren), 32'd1);
      exp_q[0] = 32'd103;
      run_drain(32'd1, 1'b0);
      check("t5_mem2", mem[2], 32'd103);

      bus.drain_start = 1'b1;
      bus.drain_base  = 32'd0;
      bus.drain_len   = 32'd0;
      step;
      bus.drain_start = 1'b0;
      check("len0_done", 32'(bus.drain_done), 32'd1);
      check("len0_valid", 32'(bus.out_valid), 32'd0);
      step;
      check("len0_idle", 32'(bus.drain_busy), 32'd0);
      check("len0_done_off", 32'(bus.drain_done), 32'd0);

      send(32'd20, 32'h7FFF_FFF0, 1'b1);
      send(32'd20, 32'h0000_0100, 1'b0);
      send(32'd21, 32'h8000_0010, 1'b1);
      send(32'd21, 32'hFFFF_FF00, 1'b0);
      step;
`ifdef PSUM_SAT_EN
      check("sat_pos", mem[20], 32'h7FFF_FFFF);
      check("sat_neg", mem[21], 32'h8000_0000);
`else
      check("wrap_pos", mem[20], 32'h8000_00F0);
      check("wrap_neg", mem[21], 32'h7FFF_FF10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
